job_sequencer: RTL

- Host-side job engine that sits directly upstream and downstream of the processor core.
- Streams an input byte block into data memory, then pulses the core's req, then waits for done (with timeout).
- Afterwards it streams a result window back out of data memory.
- Owns the data-memory port except while the core is running; the top level muxes memory on mem_sel.

---
 rtl/job_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : job_sequencer
//  Purpose  : Host-side job engine wrapped around the processor core.
//             A job streams LOAD_LEN input bytes into data memory, pulses the
//             core's proc_req, waits for proc_done (bounded by TIMEOUT run
//             cycles), then streams UNLOAD_LEN result bytes back out of data
//             memory. The block owns the data-memory port except while the
//             core is running; mem_sel tells the top level which side drives.
//
//  Ports    :
//    clk          in   1    clock, rising edge
//    reset        in   1    asynchronous active-high reset
//    start        in   1    begin a job (only sampled in IDLE)
//    in_valid     in   1    load byte valid
//    in_data      in   8    load byte
//    in_ready     out  1    load byte accepted on in_valid && in_ready
//    out_valid    out  1    result byte valid
//    out_data     out  8    result byte
//    out_ready    in   1    result byte consumed on out_valid && out_ready
//    mem_sel      out  1    1 = this block drives memory, 0 = core owns it
//    mem_wr_en    out  1    data-memory write strobe
//    mem_addr     out  AW   data-memory address
//    mem_wr_data  out  8    data-memory write data
//    mem_rd_data  in   8    data-memory read data (same-cycle read)
//    proc_req     out  1    one-cycle start pulse to the core
//    proc_done    in   1    core done level
//    busy         out  1    high in every state except IDLE
//    job_done     out  1    one-cycle pulse at job end
//    timeout      out  1    sticky: last job was aborted by the run timer
//
//  Revision : 1.0  initial release
// ============================================================================
module job_sequencer #(
    parameter int AW          = 8,
    parameter int LOAD_BASE   = 0,
    parameter int LOAD_LEN    = 64,
    parameter int UNLOAD_BASE = 64,
    parameter int UNLOAD_LEN  = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          proc_req,
    input  logic          proc_done,
    output logic          busy,
    output logic          job_done,
    output logic          timeout
);

    // Byte counter carries one extra bit so a full 2^AW-byte transfer fits.
    localparam int CW = AW + 1;
    // Run timer only needs to reach TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [AW-1:0] c_load_base   = AW'(LOAD_BASE);
    localparam logic [AW-1:0] c_unload_base = AW'(UNLOAD_BASE);
    localparam logic [CW-1:0] c_load_last   = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0] c_unload_last = CW'(UNLOAD_LEN - 1);
    localparam logic [CW-1:0] c_cnt_one     = CW'(1);
    localparam logic [TW-1:0] c_timer_last  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] c_timer_one   = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_KICK   = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_timeout;

    logic            w_load_fire;
    logic            w_unload_fire;

    assign timeout = r_timeout;

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_load_fire   = 1'b0;
        w_unload_fire = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_data      = 8'h00;
        mem_sel       = 1'b1;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_wr_data   = 8'h00;
        proc_req      = 1'b0;
        busy          = 1'b1;
        job_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                in_ready    = 1'b1;
                w_load_fire = in_valid;
                mem_wr_en   = in_valid;
                // Natural AW-bit wrap gives the modulo-2^AW address.
                mem_addr    = c_load_base + r_cnt[AW-1:0];
                mem_wr_data = in_data;
                if (in_valid && (r_cnt == c_load_last)) begin
                    w_state_nxt = ST_KICK;
                end
            end

            ST_KICK: begin
                mem_sel     = 1'b0;
                proc_req    = 1'b1;
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                mem_sel = 1'b0;
                // A done level left over from the previous job may still be
                // high on the first run cycle, so it is only trusted once the
                // timer has moved. Done takes priority over the timeout.
                if (proc_done && (r_timer != '0)) begin
                    w_state_nxt = ST_UNLOAD;
                end else if (r_timer == c_timer_last) begin
                    w_state_nxt = ST_FINISH;
                end
            end

            ST_UNLOAD: begin
                out_valid     = 1'b1;
                mem_addr      = c_unload_base + r_cnt[AW-1:0];
                out_data      = mem_rd_data;
                w_unload_fire = out_ready;
                if (out_ready && (r_cnt == c_unload_last)) begin
                    w_state_nxt = ST_FINISH;
                end
            end

            ST_FINISH: begin
                job_done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, counters and sticky timeout flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (w_load_fire) begin
                        if (r_cnt == c_load_last) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end

                ST_KICK: begin
                    r_timer <= '0;
                end

                ST_RUN: begin
                    r_timer <= r_timer + c_timer_one;
                    if (w_state_nxt == ST_UNLOAD) begin
                        r_cnt <= '0;
                    end else if (w_state_nxt == ST_FINISH) begin
                        r_timeout <= 1'b1;
                    end
                end

                ST_UNLOAD: begin
                    if (w_unload_fire) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
